// File: rtl/btn_debounce_pulse_pkg.sv
// btn_debounce_pulse_pkg: debounce FSM state encoding and default stability length
package btn_debounce_pulse_pkg;
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;
  localparam int DB_CYCLES_DEF = 4;
endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, s1} <= 2'b00;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronizes and debounces a raw button into a level plus rise/fall pulses
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter  int DB_CYCLES = DB_CYCLES_DEF,
  localparam int CNT_W     = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sync2, level_n, rise_n, fall_n;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(btn_in), .q(sync2));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  // cnt holds at CNT_MAX on acceptance; it is cleared on the next WAIT entry
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_LOW:
        if (sync2) begin
          state_n = S_WAIT_HIGH;
          cnt_n   = '0;
        end
      S_WAIT_HIGH:
        if (!sync2) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) state_n = S_HIGH;
        else cnt_n = cnt + 1'b1;
      S_HIGH:
        if (!sync2) begin
          state_n = S_WAIT_LOW;
          cnt_n   = '0;
        end
      default:
        if (sync2) begin
          state_n = S_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) state_n = S_LOW;
        else cnt_n = cnt + 1'b1;
    endcase
  end
  // leaving a WAIT state toward the opposite stable state only happens on acceptance
  always_comb begin
    rise_n  = state == S_WAIT_HIGH && state_n == S_HIGH;
    fall_n  = state == S_WAIT_LOW && state_n == S_LOW;
    level_n = rise_n ? 1'b1 : fall_n ? 1'b0 : level;
  end
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: vector table plus hand sequences for the debouncer and a downstream enabled flop
module tb_btn_debounce_pulse;
  typedef struct {
    logic       b;
    logic [2:0] o;
    int         id;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_in = 1'b1;
  logic       level, rise, fall, q;
  logic [2:0] sb[$];
  vec_t       tbl[$];
  int         n_chk = 0;
  int         n_fail = 0;
  btn_debounce_pulse #(.DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .level(level), .rise(rise), .fall(fall)
  );
  always #10 clk = ~clk;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else if (rise) q <= level;
  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic b, input logic [2:0] o, input string name);
    logic [2:0] e;
    @(negedge clk);
    btn_in = b;
    sb.push_back(o);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(name, {level, rise, fall}, e);
  endtask
  task automatic add(input logic b, input logic [2:0] o, input int n, input int id);
    for (int i = 0; i < n; i++) tbl.push_back('{b, o, id});
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #5 chk("rst_t5", {level, rise, fall}, 3'b000);
    #10 chk("rst_t15", {level, rise, fall}, 3'b000);
    #9 chk("rst_t24", {level, rise, fall}, 3'b000);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 chk("rst_e0", {level, rise, fall}, 3'b000);
    for (int i = 0; i < 5; i++) step(1'b1, 3'b000, "rst_wait");
    step(1'b1, 3'b110, "rst_rise");
    step(1'b1, 3'b100, "rst_level");
    add(1'b0, 3'b100, 6, 1);
    add(1'b0, 3'b001, 1, 1);
    add(1'b0, 3'b000, 3, 1);
    add(1'b1, 3'b000, 6, 2);
    add(1'b1, 3'b110, 1, 2);
    add(1'b1, 3'b100, 3, 2);
    add(1'b0, 3'b100, 6, 2);
    add(1'b0, 3'b001, 1, 2);
    add(1'b0, 3'b000, 3, 2);
    add(1'b1, 3'b000, 3, 3);
    add(1'b0, 3'b000, 1, 3);
    add(1'b1, 3'b000, 2, 3);
    add(1'b0, 3'b000, 8, 3);
    add(1'b1, 3'b000, 1, 4);
    add(1'b0, 3'b000, 1, 4);
    add(1'b1, 3'b000, 1, 4);
    add(1'b0, 3'b000, 1, 4);
    add(1'b1, 3'b000, 6, 4);
    add(1'b1, 3'b110, 1, 4);
    add(1'b1, 3'b100, 3, 4);
    add(1'b0, 3'b100, 6, 5);
    add(1'b0, 3'b001, 1, 5);
    add(1'b0, 3'b000, 3, 5);
    foreach (tbl[i]) step(tbl[i].b, tbl[i].o, $sformatf("vec%0d_s%0d", i, tbl[i].id));
    for (int i = 0; i < 4; i++) step(1'b1, 3'b000, "mid_pre");
    reset = 1'b0;
    #1 chk("mid_rst", {level, rise, fall}, 3'b000);
    #3 reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 3'b000, "mid_wait");
    step(1'b1, 3'b110, "mid_rise");
    step(1'b1, 3'b100, "mid_level");
    for (int i = 0; i < 6; i++) step(1'b0, 3'b100, "cancel_wait");
    step(1'b0, 3'b001, "cancel_fall");
    reset = 1'b0;
    #1 chk("cancel_rst", {level, rise, fall}, 3'b000);
    #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, "cancel_post");
    for (int i = 0; i < 6; i++) step(1'b1, 3'b000, "dff_wait");
    step(1'b1, 3'b110, "dff_rise");
    chk("dff_q_pre", {2'b00, q}, 3'b000);
    step(1'b1, 3'b100, "dff_level");
    chk("dff_q_set", {2'b00, q}, 3'b001);
    for (int i = 0; i < 4; i++) step(1'b1, 3'b100, "dff_hold");
    for (int i = 0; i < 6; i++) step(1'b0, 3'b100, "dff_rel_wait");
    step(1'b0, 3'b001, "dff_fall");
    step(1'b0, 3'b000, "dff_low");
    chk("dff_q_hold", {2'b00, q}, 3'b001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
